// File: rtl/dmem_access_ctrl_if.sv
// Memory-side request/acknowledge bus of the data-memory access controller.
// The controller drives the request half; the memory returns a one-cycle ack with read data.
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage controller: one request per load/store, pipeline freeze until ack or timeout,
// then a single DONE cycle that presents load data / status while the pipeline advances.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       MemRead_i,
    input  logic                       MemWrite_i,
    input  logic [31:0]                Addr_i,
    input  logic [31:0]                WData_i,
    dmem_access_ctrl_if.master         mem,
    output logic                       stall_o,
    output logic [31:0]                RData_o,
    output logic                       RData_valid_o,
    output logic                       misalign_o,
    output logic                       timeout_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

    state_t      state, stateNext;
    logic        access, aligned;
    logic        startAccess, ackTaken, timeoutHit;
    logic [7:0]  waitCnt;
    logic        reqQ, weQ, readQ, timedOutQ;
    logic [31:0] addrQ, wdataQ, rdataQ;

    assign access  = MemRead_i | MemWrite_i;
    assign aligned = (Addr_i[1:0] == 2'b00);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        stateNext     = state;
        startAccess   = 1'b0;
        ackTaken      = 1'b0;
        timeoutHit    = 1'b0;
        stall_o       = 1'b0;
        misalign_o    = 1'b0;
        RData_valid_o = 1'b0;
        timeout_o     = 1'b0;
        case (state)
            IDLE: begin
                if (access && aligned) begin
                    stall_o     = 1'b1;
                    startAccess = 1'b1;
                    stateNext   = BUSY;
                end else if (access) begin
                    misalign_o = 1'b1;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (mem.mem_ack) begin
                    ackTaken  = 1'b1;
                    stateNext = DONE;
                end else if (waitCnt == LastCount) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end
            end
            // DONE never looks at access: EX/MEM still holds the finished instruction.
            DONE: begin
                RData_valid_o = readQ & ~timedOutQ;
                timeout_o     = timedOutQ;
                stateNext     = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // Combinational flags must read zero while reset is held, even with an access presented.
        if (!rst_n_i) begin
            stall_o    = 1'b0;
            misalign_o = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; every register, including the
    // data buses, is cleared by the asynchronous reset so outputs are defined immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            waitCnt   <= 8'd0;
            reqQ      <= 1'b0;
            weQ       <= 1'b0;
            readQ     <= 1'b0;
            timedOutQ <= 1'b0;
            addrQ     <= 32'd0;
            wdataQ    <= 32'd0;
            rdataQ    <= 32'd0;
        end else begin
            if (startAccess) begin
                waitCnt   <= 8'd0;
                reqQ      <= 1'b1;
                weQ       <= MemWrite_i;
                readQ     <= ~MemWrite_i;
                timedOutQ <= 1'b0;
                addrQ     <= {Addr_i[31:2], 2'b00};
                wdataQ    <= WData_i;
            end
            if (state == BUSY) waitCnt <= waitCnt + 8'd1;
            if (ackTaken) begin
                reqQ <= 1'b0;
                if (!weQ) rdataQ <= mem.mem_rdata;
            end
            if (timeoutHit) begin
                reqQ      <= 1'b0;
                rdataQ    <= 32'd0;
                timedOutQ <= 1'b1;
            end
        end
    end

    assign mem.mem_req   = reqQ;
    assign mem.mem_we    = weQ;
    assign mem.mem_addr  = addrQ;
    assign mem.mem_wdata = wdataQ;
    assign RData_o       = misalign_o ? 32'd0 : rdataQ;

endmodule
